ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit for the RV32 core. Owns the program counter, issues word reads to instruction memory, and buffers returned words with their PCs in a small FIFO. Presents `instr_o`/`pc_o` to decode, which drives the immediate extension unit. Branch and jump redirects arrive from execute and flush all in-flight fetch state.

## Interface
- `RESET_PC`, `32'h0000_0000`: first fetch address after reset.
- `FIFO_DEPTH`, `2`: instruction buffer entries; power of two, ≥2.

- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `imem_req_o` out 1: read request valid this cycle.
- `imem_addr_o` out 32: word address, bits [1:0] always 0.
- `imem_gnt_i` in 1: memory accepts request (meaningful only with `imem_req_o`).
- `imem_rvalid_i` in 1: read data valid.
- `imem_rdata_i` in 32: read data.
- `redirect_i` in 1: taken branch/jump/trap; flush and refetch.
- `redirect_pc_i` in 32: new PC; bits [1:0] ignored (treated as 0).
- `instr_valid_o` out 1: FIFO head valid.
- `instr_ready_i` in 1: decode accepts head.
- `instr_o` out 32: head instruction word.
- `pc_o` out 32: head instruction address.

## Operation
- Registers: `fetch_pc` (next address to request), `req_pc` (address of outstanding request), FSM, FIFO of {pc, instr}.
- At most one outstanding memory request.
- FSM states:
  - REQ: `imem_req_o = !full && !redirect_i`; `imem_addr_o = fetch_pc`. On `req && gnt`: `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`, go to WAIT.
  - WAIT: on `imem_rvalid_i` with no redirect: push {`req_pc`, `imem_rdata_i`}, go to REQ. On redirect without rvalid: go to DROP. On redirect with rvalid in the same cycle: discard data, go to REQ.
  - DROP: outstanding response is stale. On `imem_rvalid_i`: discard, go to REQ. A redirect in DROP only updates `fetch_pc`.
- Redirect, in any state:
  - `fetch_pc <= {redirect_pc_i[31:2], 2'b00}`.
  - FIFO cleared.
  - Redirect has priority over every push and PC increment that cycle.
- Pop when `instr_valid_o && instr_ready_i`. A handshake in a redirect cycle counts as completed; decode kills it.
- Full: no request is issued. Rvalid can never arrive into a full FIFO, because issue requires `count < FIFO_DEPTH` and the FIFO only drains while a request is pending.
- Simultaneous push and pop: both take effect and count is unchanged.
- `fetch_pc` wraps from `32'hFFFF_FFFC` to `32'h0000_0000`.
- `imem_req_o` is per-cycle. If a redirect withdraws an un-granted request, the memory sees no request.

## Timing
- Reset values:
  - FSM = REQ, `fetch_pc = RESET_PC`, FIFO empty.
  - `instr_valid_o = 0`, `instr_o = 0`, `pc_o = 0`.
  - `imem_req_o = 0` while `rst_i` is high.
  - `imem_addr_o = RESET_PC`.
- First request: the cycle after `rst_i` deasserts.
- Reset asserted mid-request abandons it. The memory must also be reset by the same `rst_i`.
- Latency: `instr_valid_o` rises the cycle after `imem_rvalid_i`.
- Gnt-to-rvalid is at least one cycle.
- Redirect:
  - `instr_valid_o = 0` the cycle after `redirect_i`.
  - New request to `redirect_pc_i` that next cycle if FSM is REQ; otherwise after the stale rvalid.
- Throughput: with single-cycle memory and `instr_ready_i = 1`, one instruction per 2 cycles.
- `instr_o`/`pc_o` hold stable while `instr_valid_o && !instr_ready_i`.
- Outputs are undefined when `instr_valid_o = 0`.

## Structure
- Shared defines header gets `RESET_PC_DEFAULT` and `INSTR_NOP` (`32'h0000_0013`, decode uses it for killed slots).
- FSM encoding stays local to `ifetch`.
- Sub-module `fetch_fifo`:
  - Synchronous FIFO, 64-bit entries, depth parameter.
  - Pointer wrap plus count.
  - `flush_i` input that clears it.
- `ifetch` holds the FSM and PC logic.

## Test plan
- Reset release, memory with 1-cycle rvalid, `instr_ready_i = 1`:
  - Requests to 0x0, 0x4, 0x8, issued every 2 cycles.
  - Outputs {pc, instr} match memory contents in order.
- `instr_ready_i = 0` for 10 cycles:
  - FIFO fills to 2 entries.
  - `imem_req_o` stays 0 and head {0x0, word0} is stable.
  - Release drains in order with no loss or duplication.
- Redirect to 0x100 while in WAIT with rvalid 3 cycles later:
  - Stale word dropped.
  - Next request address is 0x100.
  - First valid output has `pc_o = 0x100`.
- Redirect coincident with rvalid: data discarded, request to the new PC next cycle.
- Redirect to 0x203: fetch address 0x200.
- `RESET_PC = 32'hFFFF_FFF8`: fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert `rst_i` while in WAIT:
  - Next cycle: `instr_valid_o = 0`, `imem_req_o = 0`.
  - After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared fetch constants, the buffered entry type and PC helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous {pc, instr} buffer with wrapping pointers and count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == c_CNT_FULL);
    assign head_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // Storage is cleared only on reset so the head reads zero out of reset;
    // a flush just rewinds the pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch.sv
// ============================================================================
// Module      : ifetch
// Description : RV32 fetch unit: PC, single-outstanding imem reads, redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam logic [1:0] c_ST_REQ  = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DROP = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_req_pc;
    logic         w_req;
    logic         w_grant;
    logic         w_push;
    logic         w_empty;
    logic         w_full;
    fetch_entry_t w_head;
    fetch_entry_t w_push_data;

    // Gating with rst_i keeps the request low for the whole reset cycle.
    assign w_req       = !rst_i && (r_state == c_ST_REQ) && !w_full && !redirect_i;
    assign w_grant     = w_req && imem_gnt_i;
    assign w_push      = (r_state == c_ST_WAIT) && imem_rvalid_i && !redirect_i;
    assign w_push_data = '{pc: r_req_pc, instr: imem_rdata_i};

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = !w_empty;
    assign instr_o       = w_head.instr;
    assign pc_o          = w_head.pc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_REQ: begin
                if (w_grant) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = c_ST_REQ;
                end else if (redirect_i) begin
                    w_state_nxt = c_ST_DROP;
                end
            end
            c_ST_DROP: begin
                if (imem_rvalid_i) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            default: w_state_nxt = c_ST_REQ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_REQ;
            r_fetch_pc <= word_align(RESET_PC);
            r_req_pc   <= word_align(RESET_PC);
        end else begin
            r_state <= w_state_nxt;
            if (redirect_i) begin
                r_fetch_pc <= word_align(redirect_pc_i);
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_grant) begin
                r_req_pc <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redirect_i),
        .push_i     (w_push),
        .push_data_i(w_push_data),
        .pop_i      (instr_valid_o && instr_ready_i),
        .head_o     (w_head),
        .empty_o    (w_empty),
        .full_o     (w_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
// ============================================================================
// Module      : tb_ifetch
// Description : Self-checking bench for ifetch against a fetch-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_log [$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops = 0;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] exp_req = RST_PC;
    int          gnt_pct = 100;
    int          ready_pct = 100;
    int          redir_permil = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          force_redir = 0;
    bit          force_on_rvalid = 0;
    logic [31:0] force_pc = '0;
    bit          prev_redirect = 0;
    bit          last_grant = 0;
    bit          hold_valid = 0;
    logic [31:0] hold_pc = '0;
    logic [31:0] hold_instr = '0;
    int          req_cyc [$];
    bit          cap_first = 0;
    logic [31:0] first_pop = '0;

    always #5 clk = ~clk;

    ifetch #(
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(2)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .instr_o      (instr),
        .pc_o         (pc)
    );

    ifetch #(
        .RESET_PC  (WRAP_PC),
        .FIFO_DEPTH(2)
    ) u_dut_wrap (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (w_req),
        .imem_addr_o  (w_addr),
        .imem_gnt_i   (1'b1),
        .imem_rvalid_i(w_rvalid),
        .imem_rdata_i (w_rdata),
        .redirect_i   (1'b0),
        .redirect_pc_i(32'h0),
        .instr_valid_o(w_valid),
        .instr_ready_i(1'b1),
        .instr_o      (w_instr),
        .pc_o         (w_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_0013;
    endfunction

    // Always-granting single-cycle memory for the wrap instance.
    always @(posedge clk) begin
        if (rst) begin
            w_rvalid <= 1'b0;
        end else begin
            w_rvalid <= w_req;
            w_rdata  <= mem_word(w_addr);
            if (w_req) w_log.push_back(w_addr);
        end
    end

    function automatic logic [31:0] rand_target();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFE0 | $urandom_range(31);
        return $urandom_range(4095);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory/decode/redirect, check outputs, advance model.
    task automatic step();
        bit take_redir;
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            if (pend_cnt == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end else begin
                pend_cnt--;
            end
        end
        imem_gnt    = (int'($urandom_range(99)) < gnt_pct);
        instr_ready = (int'($urandom_range(99)) < ready_pct);
        take_redir  = force_redir || (force_on_rvalid && imem_rvalid) ||
                      (int'($urandom_range(999)) < redir_permil);
        redirect    = take_redir;
        redirect_pc = (force_redir || force_on_rvalid) ? force_pc : rand_target();
        if (take_redir) begin
            force_redir     = 0;
            force_on_rvalid = 0;
        end
        #1;
        if (prev_redirect) chk("valid_after_redirect", 32'(instr_valid), 32'd0);
        if (hold_valid) begin
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_pc", pc, hold_pc);
            chk("hold_instr", instr, hold_instr);
        end
        if (imem_req) begin
            chk("req_addr", imem_addr, exp_req);
            chk("single_outstanding", 32'(pend), 32'd0);
        end
        if (instr_valid && instr_ready) begin
            chk("pop_pc", pc, exp_pc);
            chk("pop_instr", instr, mem_word(exp_pc));
            if (cap_first) begin
                first_pop = pc;
                cap_first = 0;
            end
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        last_grant = imem_req && imem_gnt;
        if (last_grant) req_cyc.push_back(cyc);
        if (redirect) begin
            exp_pc  = {redirect_pc[31:2], 2'b00};
            exp_req = {redirect_pc[31:2], 2'b00};
        end else if (last_grant) begin
            exp_req = exp_req + 32'd4;
        end
        if (imem_rvalid) pend = 0;
        if (last_grant) begin
            pend      = 1;
            pend_cnt  = int'($urandom_range(lat_max, lat_min));
            pend_addr = imem_addr;
        end
        hold_valid    = instr_valid && !instr_ready && !redirect;
        hold_pc       = pc;
        hold_instr    = instr;
        prev_redirect = redirect;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        pend          = 0;
        exp_pc        = RST_PC;
        exp_req       = RST_PC;
        prev_redirect = 0;
        hold_valid    = 0;
        rst           = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset(2);

        // Back-to-back fetch with 1-cycle memory and an always-ready decode.
        req_cyc.delete();
        repeat (8) step();
        chk("three_requests", 32'(req_cyc.size() >= 3), 32'd1);
        if (req_cyc.size() >= 3) begin
            chk("req_spacing_01", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
            chk("req_spacing_12", 32'(req_cyc[2] - req_cyc[1]), 32'd2);
        end

        // Reset while a response is outstanding.
        last_grant = 0;
        for (int i = 0; i < 20 && !last_grant; i++) step();
        chk("grant_before_reset", 32'(last_grant), 32'd1);
        do_reset(1);

        // Stalled decode: buffer fills, requests stop, head is held.
        ready_pct = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 6) begin
                chk("full_valid", 32'(instr_valid), 32'd1);
                chk("full_no_req", 32'(imem_req), 32'd0);
                chk("full_head_pc", pc, RST_PC);
                chk("full_head_instr", instr, mem_word(RST_PC));
            end
        end
        ready_pct = 100;
        repeat (10) step();

        // Redirect while waiting on a slow response.
        lat_min = 3;
        lat_max = 3;
        last_grant = 0;
        for (int i = 0; i < 20 && !last_grant; i++) step();
        chk("grant_before_redirect", 32'(last_grant), 32'd1);
        force_redir = 1;
        force_pc    = 32'h0000_0100;
        step();
        cap_first = 1;
        first_pop = 32'hDEAD_BEEF;
        repeat (14) step();
        chk("first_pop_after_redirect", first_pop, 32'h0000_0100);

        // Redirect landing in the same cycle as the response.
        lat_min = 2;
        lat_max = 2;
        force_on_rvalid = 1;
        force_pc        = 32'h0000_0340;
        for (int i = 0; i < 10 && force_on_rvalid; i++) step();
        chk("coincident_fired", 32'(force_on_rvalid), 32'd0);
        step();
        chk("coincident_req", 32'(imem_req), 32'd1);
        chk("coincident_addr", imem_addr, 32'h0000_0340);

        // Unaligned redirect target.
        lat_min = 1;
        lat_max = 1;
        force_redir = 1;
        force_pc    = 32'h0000_0203;
        step();
        for (int i = 0; i < 10 && !imem_req; i++) step();
        chk("align_req", 32'(imem_req), 32'd1);
        chk("align_addr", imem_addr, 32'h0000_0200);
        repeat (6) step();

        // Randomised traffic.
        pops         = 0;
        gnt_pct      = 70;
        ready_pct    = 60;
        redir_permil = 50;
        lat_min      = 1;
        lat_max      = 4;
        repeat (1500) step();
        chk("random_progress", 32'(pops >= 100), 32'd1);

        // Wrap-around fetch from the top of the address space.
        chk("wrap_log_size", 32'(w_log.size() >= 3), 32'd1);
        if (w_log.size() >= 3) begin
            chk("wrap_addr0", w_log[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", w_log[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", w_log[2], 32'h0000_0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
